// File: rtl/spi_flash_reader_if.sv
// Bundle between the flash-read sequencer, its requester/consumer and the SPI byte engine.
interface spi_flash_reader_if #(
  parameter int LEN_W = 16
);
  logic             start;
  logic [23:0]      addr;
  logic [LEN_W-1:0] len;
  logic             busy;
  logic             done;
  logic [7:0]       data_out;
  logic             data_valid;
  logic             data_ready;
  logic             spi_load;
  logic [15:0]      spi_in;
  logic [15:0]      spi_out;

  modport master (
    output start, addr, len, data_ready, spi_out,
    input  busy, done, data_out, data_valid, spi_load, spi_in
  );

  modport slave (
    input  start, addr, len, data_ready, spi_out,
    output busy, done, data_out, data_valid, spi_load, spi_in
  );
endinterface

// File: rtl/spi_flash_reader.sv
// SPI-flash READ sequencer: sends CMD + 24-bit address + dummy bytes through the SPI
// byte engine and streams the received bytes out on a valid/ready port.
module spi_flash_reader #(
  parameter logic [7:0] CMD   = 8'h03,
  parameter int         LEN_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  spi_flash_reader_if.slave bus
);

  typedef enum logic [2:0] {
    INIT, IDLE, LOAD, WAIT, PRESENT, DESEL, DESEL_WAIT, DONE
  } state_t;

  state_t           state, state_nxt;
  logic [23:0]      addr_q;
  logic [LEN_W-1:0] rem_q, rem_nxt;
  logic [2:0]       idx_q, idx_nxt;
  logic             init_q, init_nxt;
  logic             first_q, first_nxt;
  logic             spi_load_q, spi_load_nxt;
  logic [15:0]      spi_in_q, spi_in_nxt;
  logic [7:0]       data_out_q, data_out_nxt;
  logic             data_valid_q, data_valid_nxt;
  logic             complete;
  logic             accept;
  logic             take_start;

  function automatic logic [7:0] byte_sel(input logic [2:0] idx, input logic [23:0] a);
    case (idx)
      3'd0:    byte_sel = CMD;
      3'd1:    byte_sel = a[23:16];
      3'd2:    byte_sel = a[15:8];
      3'd3:    byte_sel = a[7:0];
      default: byte_sel = 8'h00;
    endcase
  endfunction

  // The engine's busy flag lags the load by a cycle, so the first wait cycle is never trusted.
  assign complete   = !first_q && !bus.spi_out[15];
  assign accept     = data_valid_q && bus.data_ready;
  assign take_start = (state == IDLE) && bus.start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= INIT;
      addr_q       <= '0;
      rem_q        <= '0;
      idx_q        <= '0;
      init_q       <= 1'b1;
      first_q      <= 1'b0;
      spi_load_q   <= 1'b0;
      spi_in_q     <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
    end else begin
      state        <= state_nxt;
      rem_q        <= rem_nxt;
      idx_q        <= idx_nxt;
      init_q       <= init_nxt;
      first_q      <= first_nxt;
      spi_load_q   <= spi_load_nxt;
      spi_in_q     <= spi_in_nxt;
      data_out_q   <= data_out_nxt;
      data_valid_q <= data_valid_nxt;
      if (take_start) addr_q <= bus.addr;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      INIT:       state_nxt = DESEL_WAIT;
      IDLE:       if (bus.start) state_nxt = (bus.len == '0) ? DONE : LOAD;
      LOAD:       state_nxt = WAIT;
      WAIT:       if (complete) state_nxt = (idx_q < 3'd4) ? LOAD : PRESENT;
      PRESENT:    if (accept) state_nxt = (rem_q == LEN_W'(1)) ? DESEL : LOAD;
      DESEL:      state_nxt = DESEL_WAIT;
      DESEL_WAIT: if (complete) state_nxt = init_q ? IDLE : DONE;
      DONE:       state_nxt = IDLE;
      default:    state_nxt = INIT;
    endcase
  end

  // Registered outputs are computed from the next state so spi_load is high during LOAD/DESEL.
  always_comb begin
    rem_nxt        = rem_q;
    idx_nxt        = idx_q;
    init_nxt       = init_q;
    data_out_nxt   = data_out_q;
    data_valid_nxt = data_valid_q;
    spi_in_nxt     = spi_in_q;
    if (take_start) begin
      rem_nxt = bus.len;
      idx_nxt = 3'd0;
    end
    if (state == WAIT && complete) begin
      if (idx_q < 3'd4) begin
        idx_nxt = idx_q + 3'd1;
      end else begin
        data_out_nxt   = bus.spi_out[7:0];
        data_valid_nxt = 1'b1;
      end
    end
    if (state == PRESENT && accept) begin
      rem_nxt        = rem_q - LEN_W'(1);
      data_valid_nxt = 1'b0;
    end
    if (state == DESEL_WAIT && complete) init_nxt = 1'b0;
    first_nxt    = (state_nxt != state) && (state_nxt == WAIT || state_nxt == DESEL_WAIT);
    spi_load_nxt = (state == INIT) || (state_nxt == LOAD) || (state_nxt == DESEL);
    if (state == INIT || state_nxt == DESEL) spi_in_nxt = 16'h0100;
    else if (state_nxt == LOAD)              spi_in_nxt = {8'h00, byte_sel(idx_nxt, addr_q)};
  end

  assign bus.busy       = (state != IDLE);
  assign bus.done       = (state == DONE);
  assign bus.spi_load   = spi_load_q;
  assign bus.spi_in     = spi_in_q;
  assign bus.data_out   = data_out_q;
  assign bus.data_valid = data_valid_q;

endmodule

// File: tb/tb_spi_flash_reader.sv
// Bench for spi_flash_reader: behavioural SPI engine, stream capture and a per-read
// expectation built from the command/address/dummy byte schedule.
module tb_spi_flash_reader;
  localparam int LEN_W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #20 clk = ~clk;

  spi_flash_reader_if #(.LEN_W(LEN_W)) bus ();
  spi_flash_reader #(.CMD(8'h03), .LEN_W(LEN_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int tests = 0;
  int fails = 0;

  logic [15:0] ld_q[$];
  logic [7:0]  rx_q[$];
  logic [7:0]  st_q[$];
  int          done_cnt = 0;
  int          viol = 0;
  int          spi_cnt = 0;
  logic        prev_load = 1'b0;

  // SPI byte engine: busy for a random number of cycles after each load, then shows a random byte.
  initial begin
    logic [7:0] rx_next;
    bus.spi_out = 16'h0000;
    forever begin
      @(negedge clk);
      if (bus.spi_load) begin
        if (spi_cnt != 0 || prev_load) viol++;
        ld_q.push_back(bus.spi_in);
        rx_next = 8'($urandom);
        rx_q.push_back(rx_next);
        spi_cnt = $urandom_range(1, 4);
        bus.spi_out = {1'b1, 7'b0, bus.spi_out[7:0]};
      end else if (spi_cnt != 0) begin
        spi_cnt--;
        if (spi_cnt == 0) bus.spi_out = {8'h00, rx_q[$]};
      end
      prev_load = bus.spi_load;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      #5;
      if (bus.done) done_cnt++;
      if (bus.data_valid && bus.data_ready) st_q.push_back(bus.data_out);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_busy"},     32'(bus.busy), 32'd1);
    check({tag, "_done"},     32'(bus.done), 32'd0);
    check({tag, "_data_out"}, 32'(bus.data_out), 32'd0);
    check({tag, "_valid"},    32'(bus.data_valid), 32'd0);
    check({tag, "_load"},     32'(bus.spi_load), 32'd0);
    check({tag, "_spi_in"},   32'(bus.spi_in), 32'd0);
  endtask

  // After reset release: exactly one deselect load, busy drops, no done pulse.
  task automatic check_init(input string tag, input int b_ld, input int b_dn);
    int cyc = 0;
    while (bus.busy && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_timeout"}, 32'(cyc < 200), 32'd1);
    check({tag, "_loads"}, 32'(ld_q.size() - b_ld), 32'd1);
    if (ld_q.size() > b_ld) check({tag, "_word"}, 32'(ld_q[b_ld]), 32'h0100);
    check({tag, "_no_done"}, 32'(done_cnt - b_dn), 32'd0);
    check({tag, "_valid"}, 32'(bus.data_valid), 32'd0);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
  endtask

  // mode 0: ready always high, 1: random ready, 2: first byte stalled 10 cycles.
  task automatic run_read(input logic [23:0] a, input int n, input int mode, input bit poke);
    int b_ld, b_st, b_dn, cyc, stall_n;
    bit stalled;
    logic [15:0] exp_in[$];
    b_ld = ld_q.size();
    b_st = st_q.size();
    b_dn = done_cnt;
    stall_n = 0;
    stalled = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.addr = a;
    bus.len = LEN_W'(n);
    bus.data_ready = (mode != 2);
    @(negedge clk);
    bus.start = 1'b0;
    check("start_busy", 32'(bus.busy), 32'd1);
    check("start_load", 32'(bus.spi_load), 32'(n != 0));
    if (n == 0) check("len0_done", 32'(bus.done), 32'd1);
    else        check("cmd_word", 32'(bus.spi_in), 32'h0003);
    cyc = 0;
    while (bus.busy && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (poke && cyc == 3) begin
        bus.start = 1'b1;
        bus.addr = 24'hFFFFFF;
        bus.len = '0;
      end else begin
        bus.start = 1'b0;
      end
      if (mode == 2 && !stalled) begin
        bus.data_ready = 1'b0;
        if (bus.data_valid) begin
          if (rx_q.size() > b_ld + 4) check("stall_data", 32'(bus.data_out), 32'(rx_q[b_ld+4]));
          check("stall_noload", 32'(bus.spi_load), 32'd0);
          stall_n++;
          if (stall_n == 10) begin
            stalled = 1'b1;
            bus.data_ready = 1'b1;
          end
        end
      end else if (mode == 1) begin
        bus.data_ready = 1'($urandom_range(0, 1));
      end else begin
        bus.data_ready = 1'b1;
      end
    end
    bus.start = 1'b0;
    bus.data_ready = 1'b1;
    check("busy_timeout", 32'(cyc < 3000), 32'd1);
    if (mode == 2) check("stall_cycles", 32'(stall_n), 32'd10);
    if (n != 0) begin
      exp_in.push_back(16'h0003);
      exp_in.push_back({8'h00, a[23:16]});
      exp_in.push_back({8'h00, a[15:8]});
      exp_in.push_back({8'h00, a[7:0]});
      for (int i = 0; i < n; i++) exp_in.push_back(16'h0000);
      exp_in.push_back(16'h0100);
    end
    check("load_count", 32'(ld_q.size() - b_ld), 32'(exp_in.size()));
    for (int i = 0; i < exp_in.size(); i++)
      if (b_ld + i < ld_q.size())
        check($sformatf("spi_in[%0d]", i), 32'(ld_q[b_ld+i]), 32'(exp_in[i]));
    check("byte_count", 32'(st_q.size() - b_st), 32'(n));
    for (int i = 0; i < n; i++)
      if (b_st + i < st_q.size() && b_ld + 4 + i < rx_q.size())
        check($sformatf("stream[%0d]", i), 32'(st_q[b_st+i]), 32'(rx_q[b_ld+4+i]));
    check("done_pulse", 32'(done_cnt - b_dn), 32'd1);
    check("idle_busy", 32'(bus.busy), 32'd0);
    check("idle_valid", 32'(bus.data_valid), 32'd0);
    check("spi_protocol", 32'(viol), 32'd0);
  endtask

  initial begin
    int b_ld, b_st, b_dn, cyc;
    bus.start = 1'b0;
    bus.addr = '0;
    bus.len = '0;
    bus.data_ready = 1'b1;

    #3 rst_n = 1'b0;
    #5;
    check_reset_values("por");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check_init("por_init", 0, 0);

    run_read(24'h012345, 2, 0, 1'b0);
    run_read(24'h012345, 2, 2, 1'b0);
    run_read(24'($urandom), 0, 0, 1'b0);
    run_read(24'h0ABCDE, 3, 1, 1'b1);
    for (int t = 0; t < 6; t++)
      run_read(24'($urandom), $urandom_range(1, 6), $urandom_range(0, 2), 1'($urandom_range(0, 1)));

    // Abort a read while its third data byte is in flight.
    b_st = st_q.size();
    @(negedge clk);
    bus.start = 1'b1;
    bus.addr = 24'($urandom);
    bus.len = LEN_W'(5);
    bus.data_ready = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 0;
    while (st_q.size() < b_st + 2 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    check("abort_timeout", 32'(cyc < 2000), 32'd1);
    @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    check_reset_values("abort");
    b_ld = ld_q.size();
    b_dn = done_cnt;
    repeat (10) @(negedge clk);
    rst_n = 1'b1;
    check_init("abort_init", b_ld, b_dn);
    check("abort_protocol", 32'(viol), 32'd0);

    run_read(24'h012345, 2, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
